// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, access-size
// codes carried on BE, load-type codes carried on FUNCT3, and the alignment and
// load-extension helpers used by mem_responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // True when the size code is one of the three legal sizes and the byte
  // offset is naturally aligned for that size.
  function automatic logic align_ok(input logic [3:0] be, input logic [1:0] off);
    logic ok;
    case (be)
      BE_B:    ok = 1'b1;
      BE_H:    ok = ~off[0];
      BE_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Extracts the addressed field from a RAM word and extends it. LW and any
  // undefined code return the whole word untouched.
  function automatic logic [31:0] load_ext(input logic [2:0] f3,
                                           input logic [31:0] word,
                                           input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (f3)
      F3_LB:   res = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   res = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  res = {24'h000000, sh[7:0]};
      F3_LHU:  res = {16'h0000, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Word-organised storage, 2^AW x 32 bits, with per-byte-lane write enables.
// Writes are synchronous, the read port is combinational; contents are never
// reset.
//   CLK    in   clock
//   addr   in   word index (shared by read and write)
//   we     in   byte-lane write enables, bit i writes wdata[8i+7:8i]
//   wdata  in   lane-aligned write data
//   rdata  out  word currently stored at addr
module mem_word_ram #(
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU memory port. Accepts a level
// MemRead/MemWrite request, waits LATENCY cycles, commits the RAM access and
// then holds READY/ERR/RDATA until the requester drops its request (4-phase).
//   CLK       in   clock
//   RST       in   asynchronous active-high reset
//   MemRead   in   read request level
//   MemWrite  in   write request level
//   BE        in   access size: 0001 byte, 0011 half, 1111 word
//   FUNCT3    in   load type (LB/LH/LW/LBU/LHU)
//   ADDR      in   byte address
//   WDATA     in   right-justified store data
//   RDATA     out  extended load data, held between responses
//   READY     out  response valid / handshake acknowledge
//   ERR       out  transaction error, valid with READY
//
// state | meaning
// IDLE  | waiting for a request; request fields latched on accept
// WAIT  | counting down wait states; commit on the edge leaving WAIT
// RESP  | READY/ERR driven until both request levels drop
module mem_responder
  import mem_pkg::*;
#(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [3:0]  BE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        READY,
  output logic        ERR
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic        wr_q;
  logic        err_q;

  logic        req;
  logic        req_err;
  logic        in_idle;
  logic        accept;
  logic        commit;

  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic [3:0]  e_be;
  logic [2:0]  e_f3;
  logic        e_wr;
  logic        e_err;
  logic [1:0]  off;

  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] rdata_next;

  assign req     = MemRead | MemWrite;
  assign in_idle = (state == IDLE);
  // READY is cleared on the RESP->IDLE edge, so the guard only matters if a
  // response is still visible; it keeps a held level from being re-accepted.
  assign accept  = in_idle & req & ~READY;

  assign req_err = ~align_ok(BE, ADDR[1:0])
                 | (|(ADDR >> (AW + 2)))
                 | (MemRead & MemWrite);

  // With LATENCY=0 the commit happens on the accept edge itself, before the
  // latches hold anything, so the access path reads the live inputs in IDLE.
  assign e_addr  = in_idle ? ADDR     : addr_q;
  assign e_wdata = in_idle ? WDATA    : wdata_q;
  assign e_be    = in_idle ? BE       : be_q;
  assign e_f3    = in_idle ? FUNCT3   : f3_q;
  assign e_wr    = in_idle ? MemWrite : wr_q;
  assign e_err   = in_idle ? req_err  : err_q;
  assign off     = e_addr[1:0];

  assign commit = (accept & (LAT == 4'd0)) | ((state == WAIT) & (cnt == 4'd1));

  assign ram_we    = (commit & e_wr & ~e_err) ? (e_be << off) : 4'b0000;
  assign ram_wdata = e_wdata << {off, 3'b000};

  mem_word_ram #(
    .AW (AW)
  ) u_ram (
    .CLK   (CLK),
    .addr  (e_addr[AW+1:2]),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    rdata_next = RDATA;
    if (e_err)      rdata_next = 32'h0;
    else if (!e_wr) rdata_next = load_ext(e_f3, ram_rdata, off);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      READY   <= 1'b0;
      ERR     <= 1'b0;
      RDATA   <= 32'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0000;
      f3_q    <= 3'b000;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= ADDR;
            wdata_q <= WDATA;
            be_q    <= BE;
            f3_q    <= FUNCT3;
            wr_q    <= MemWrite;
            err_q   <= req_err;
            cnt     <= LAT;
            if (LAT == 4'd0) begin
              state <= RESP;
              RDATA <= rdata_next;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            RDATA <= rdata_next;
          end
        end
        RESP: begin
          if (!req) begin
            state <= IDLE;
            READY <= 1'b0;
            ERR   <= 1'b0;
          end else begin
            READY <= 1'b1;
            ERR   <= err_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  mr;
  logic [2:0]  mw;
  logic [3:0]  BE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic [31:0] rdata0, rdata1, rdata2;
  logic [2:0]  ready;
  logic [2:0]  err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last [3];
  int          lat_of [3];

  always #5 CLK = ~CLK;

  mem_responder #(.AW(10), .LATENCY(2)) u_l2 (
    .CLK(CLK), .RST(RST), .MemRead(mr[0]), .MemWrite(mw[0]), .BE(BE),
    .FUNCT3(FUNCT3), .ADDR(ADDR), .WDATA(WDATA), .RDATA(rdata0),
    .READY(ready[0]), .ERR(err[0]));

  mem_responder #(.AW(10), .LATENCY(0)) u_l0 (
    .CLK(CLK), .RST(RST), .MemRead(mr[1]), .MemWrite(mw[1]), .BE(BE),
    .FUNCT3(FUNCT3), .ADDR(ADDR), .WDATA(WDATA), .RDATA(rdata1),
    .READY(ready[1]), .ERR(err[1]));

  mem_responder #(.AW(10), .LATENCY(3)) u_l3 (
    .CLK(CLK), .RST(RST), .MemRead(mr[2]), .MemWrite(mw[2]), .BE(BE),
    .FUNCT3(FUNCT3), .ADDR(ADDR), .WDATA(WDATA), .RDATA(rdata2),
    .READY(ready[2]), .ERR(err[2]));

  function automatic logic [31:0] rdata_of(input int d);
    logic [31:0] r;
    case (d)
      0:       r = rdata0;
      1:       r = rdata1;
      default: r = rdata2;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One 4-phase transaction on DUT d. addr2 is driven on ADDR right after the
  // accept edge; hold keeps the request up for extra cycles after READY.
  task automatic txn(input int d, input logic rd, input logic wr,
                     input logic [3:0] be, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] addr2,
                     input logic [31:0] wdata, input logic [31:0] rexp,
                     input logic eexp, input int hold, input string tag);
    exp_t e;
    int   n;
    bit   seen;
    e.err   = eexp;
    e.rdata = eexp ? 32'h0 : (wr ? last[d] : rexp);
    e.lat   = lat_of[d] + 1;
    sb.push_back(e);
    last[d] = e.rdata;

    BE = be; FUNCT3 = f3; ADDR = addr; WDATA = wdata;
    mr[d] = rd; mw[d] = wr;
    @(posedge CLK); #1;
    ADDR = addr2;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge CLK); #1;
      n++;
      if (ready[d]) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s timeout observed_ready=0 expected_ready=1", tag);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"},   32'(n),           32'(e.lat));
      chk({tag, "_err"},   {31'h0, err[d]},  {31'h0, e.err});
      chk({tag, "_rdata"}, rdata_of(d),      e.rdata);
      for (int i = 0; i < hold; i++) begin
        @(posedge CLK); #1;
        chk({tag, "_held"}, {31'h0, ready[d]}, 32'h1);
      end
    end
    mr[d] = 1'b0; mw[d] = 1'b0;
    @(posedge CLK); #1;
    chk({tag, "_drop"}, {31'h0, ready[d]}, 32'h0);
    @(posedge CLK); #1;
  endtask

  initial begin
    lat_of[0] = 2; lat_of[1] = 0; lat_of[2] = 3;
    for (int i = 0; i < 3; i++) last[i] = 32'h0;
    RST = 1'b1; mr = 3'b000; mw = 3'b000;
    BE = 4'b0000; FUNCT3 = 3'b000; ADDR = 32'h0; WDATA = 32'h0;
    #12;
    chk("rst_ready", {29'h0, ready}, 32'h0);
    chk("rst_err",   {29'h0, err},   32'h0);
    chk("rst_rdata", rdata0,         32'h0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // word store and load back
    txn(0, 0, 1, 4'b1111, 3'b010, 32'h10, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, "sw10");
    txn(0, 1, 0, 4'b1111, 3'b010, 32'h10, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, "lw10");

    // byte merge and extended loads
    txn(0, 0, 1, 4'b0001, 3'b000, 32'h11, 32'h11, 32'h00000055, 32'h0,        0, 0, "sb11");
    txn(0, 1, 0, 4'b1111, 3'b010, 32'h10, 32'h10, 32'h0,        32'hDEAD55EF, 0, 0, "lw10_sb");
    txn(0, 1, 0, 4'b0001, 3'b000, 32'h13, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 0, "lb13");
    txn(0, 1, 0, 4'b0001, 3'b100, 32'h13, 32'h13, 32'h0,        32'h000000DE, 0, 0, "lbu13");
    txn(0, 1, 0, 4'b0011, 3'b101, 32'h12, 32'h12, 32'h0,        32'h0000DEAD, 0, 0, "lhu12");
    txn(0, 1, 0, 4'b0011, 3'b001, 32'h12, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 0, "lh12");
    txn(0, 1, 0, 4'b0011, 3'b001, 32'h10, 32'h10, 32'h0,        32'h000055EF, 0, 0, "lh10");
    txn(0, 1, 0, 4'b0001, 3'b011, 32'h10, 32'h10, 32'h0,        32'hDEAD55EF, 0, 0, "f3_undef");

    // errors: misaligned, out of range, illegal size
    txn(0, 1, 0, 4'b1111, 3'b010, 32'h12,   32'h12,   32'h0,        32'h0,        1, 0, "lw12_mis");
    txn(0, 0, 1, 4'b0011, 3'b001, 32'h11,   32'h11,   32'h0000BEEF, 32'h0,        1, 0, "sh11_mis");
    txn(0, 1, 0, 4'b1111, 3'b010, 32'h10,   32'h10,   32'h0,        32'hDEAD55EF, 0, 0, "lw10_unch");
    txn(0, 1, 0, 4'b1111, 3'b010, 32'h1000, 32'h1000, 32'h0,        32'h0,        1, 0, "lw_oor");
    txn(0, 0, 1, 4'b0111, 3'b010, 32'h10,   32'h10,   32'h01020304, 32'h0,        1, 0, "sw_badbe");
    txn(0, 1, 0, 4'b1111, 3'b010, 32'h10,   32'h10,   32'h0,        32'hDEAD55EF, 0, 0, "lw10_unch2");

    // half store into upper lanes
    txn(0, 0, 1, 4'b0011, 3'b001, 32'h12, 32'h12, 32'hFFFF1234, 32'h0,        0, 0, "sh12");
    txn(0, 1, 0, 4'b1111, 3'b010, 32'h10, 32'h10, 32'h0,        32'h123455EF, 0, 0, "lw10_sh");
    txn(0, 1, 0, 4'b0001, 3'b000, 32'h11, 32'h11, 32'h0,        32'h00000055, 0, 0, "lb11");

    // read+write conflict, held request not re-accepted
    txn(0, 0, 1, 4'b1111, 3'b010, 32'h30, 32'h30, 32'h11112222, 32'h0,        0, 0, "sw30");
    txn(0, 1, 1, 4'b1111, 3'b010, 32'h30, 32'h30, 32'h99999999, 32'h0,        1, 3, "rw_conf");
    txn(0, 1, 0, 4'b1111, 3'b010, 32'h30, 32'h30, 32'h0,        32'h11112222, 0, 0, "lw30");

    // reset during WAIT of a store
    txn(0, 0, 1, 4'b1111, 3'b010, 32'h20, 32'h20, 32'h12345678, 32'h0,        0, 0, "sw20");
    txn(0, 1, 0, 4'b1111, 3'b010, 32'h20, 32'h20, 32'h0,        32'h12345678, 0, 0, "lw20");
    BE = 4'b1111; FUNCT3 = 3'b010; ADDR = 32'h20; WDATA = 32'hAAAA5555;
    mw[0] = 1'b1;
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    chk("midrst_ready", {31'h0, ready[0]}, 32'h0);
    chk("midrst_rdata", rdata0,            32'h0);
    chk("midrst_err",   {31'h0, err[0]},   32'h0);
    mw[0] = 1'b0;
    for (int i = 0; i < 3; i++) last[i] = 32'h0;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    txn(0, 1, 0, 4'b1111, 3'b010, 32'h20, 32'h20, 32'h0,        32'h12345678, 0, 0, "lw20_rst");

    // zero wait states
    txn(1, 0, 1, 4'b0001, 3'b000, 32'h8, 32'h8, 32'h000000A5, 32'h0,        0, 0, "l0_sb8");
    txn(1, 1, 0, 4'b0001, 3'b000, 32'h8, 32'h8, 32'h0,        32'hFFFFFFA5, 0, 0, "l0_lb8");
    txn(1, 1, 0, 4'b1111, 3'b010, 32'h9, 32'h9, 32'h0,        32'h0,        1, 0, "l0_mis");

    // address changed during WAIT is ignored
    txn(2, 0, 1, 4'b1111, 3'b010, 32'h40, 32'h40, 32'hCAFEF00D, 32'h0,        0, 0, "l3_sw40");
    txn(2, 0, 1, 4'b1111, 3'b010, 32'h44, 32'h44, 32'h0BADBEEF, 32'h0,        0, 0, "l3_sw44");
    txn(2, 1, 0, 4'b1111, 3'b010, 32'h40, 32'h44, 32'h0,        32'hCAFEF00D, 0, 0, "l3_lw40_chg");
    txn(2, 1, 0, 4'b1111, 3'b010, 32'h44, 32'h44, 32'h0,        32'h0BADBEEF, 0, 0, "l3_lw44");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
